// File: rtl/xor_write_pipe_uram_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xor_write_pipe_uram_if : op, bank-read, table-write and drain signals of the
// XOR write pipe. Rev 1.0
// ---------------------------------------------------------------------------
interface xor_write_pipe_uram_if #(
  parameter int NUM_MUL     = 4,
  parameter int NUM_WR      = 8,
  parameter int INDEX_WIDTH = 12,
  parameter int VALUE_WIDTH = 31,
  parameter int KEY_WIDTH   = 32,
  parameter int DATA_WIDTH  = 64
);
  logic                                    en_in;
  logic [1:0]                              opt_in;
  logic [INDEX_WIDTH-1:0]                  index_in;
  logic [KEY_WIDTH-1:0]                    key_in;
  logic [VALUE_WIDTH-1:0]                  value_in;
  logic                                    in_ready;
  logic                                    rd_en_out;
  logic [INDEX_WIDTH-1:0]                  rd_index_out;
  logic [NUM_MUL*(NUM_WR-1)*DATA_WIDTH-1:0] rd_other_in;
  logic                                    wr_en_out;
  logic [INDEX_WIDTH-1:0]                  wr_index_out;
  logic [NUM_MUL*DATA_WIDTH-1:0]           wr_data_out;
  logic                                    drain_req;
  logic                                    drain_ack;
  logic [2:0]                              in_flight;

  modport master (
    output en_in, opt_in, index_in, key_in, value_in, rd_other_in, drain_req,
    input  in_ready, rd_en_out, rd_index_out, wr_en_out, wr_index_out,
           wr_data_out, drain_ack, in_flight
  );

  modport slave (
    input  en_in, opt_in, index_in, key_in, value_in, rd_other_in, drain_req,
    output in_ready, rd_en_out, rd_index_out, wr_en_out, wr_index_out,
           wr_data_out, drain_ack, in_flight
  );
endinterface
`default_nettype wire

// File: rtl/xor_write_pipe_uram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xor_write_pipe_uram : insert/delete write path; reads other URAM banks and
// XOR-merges them per table. Macro XORW_COALESCE_EN squashes superseded ops.
// Rev 1.0
// ---------------------------------------------------------------------------
module xor_write_pipe_uram #(
  parameter int NUM_MUL     = 4,
  parameter int NUM_WR      = 8,
  parameter int INDEX_WIDTH = 12,
  parameter int VALUE_WIDTH = 31,
  parameter int KEY_WIDTH   = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int RD_LAT      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  xor_write_pipe_uram_if.slave bus
);
  localparam int OTHERS  = NUM_WR - 1;
  localparam int ENT_MSB = KEY_WIDTH + VALUE_WIDTH;
  localparam int LAST    = RD_LAT - 1;

  logic                          accept;
  logic [DATA_WIDTH-1:0]         entry;

  logic                          s0_vld_q;
  logic [INDEX_WIDTH-1:0]        s0_idx_q;
  logic [DATA_WIDTH-1:0]         s0_ent_q;

  logic [RD_LAT-1:0]             dl_vld_q;
  logic [RD_LAT-1:0]             dl_vld_d;
  logic [INDEX_WIDTH-1:0]        dl_idx_q [RD_LAT];
  logic [DATA_WIDTH-1:0]         dl_ent_q [RD_LAT];

  logic                          s0_kill;
  logic [RD_LAT-1:0]             dl_kill;

  logic                          wr_en_q;
  logic                          wr_en_d;
  logic [INDEX_WIDTH-1:0]        wr_idx_q;
  logic [NUM_MUL*DATA_WIDTH-1:0] wr_data_q;
  logic [NUM_MUL*DATA_WIDTH-1:0] wr_data_d;

  logic [2:0]                    flight;

  assign bus.in_ready = ~bus.drain_req;
  assign accept       = bus.en_in && (bus.opt_in != 2'b00) && !bus.drain_req;

  // Stored word: {zero pad, insert flag, value, key}; opt 10 counts as delete.
  always_comb begin
    entry                           = '0;
    entry[KEY_WIDTH-1:0]            = bus.key_in;
    entry[KEY_WIDTH +: VALUE_WIDTH] = bus.value_in;
    entry[ENT_MSB]                  = ~bus.opt_in[1];
  end

`ifdef XORW_COALESCE_EN
  // A newer op to the same index makes every older pre-output op redundant.
  always_comb begin
    s0_kill = accept && s0_vld_q && (s0_idx_q == bus.index_in);
    dl_kill = '0;
    for (int k = 0; k < RD_LAT; k++) begin
      dl_kill[k] = accept && dl_vld_q[k] && (dl_idx_q[k] == bus.index_in);
    end
  end
`else
  assign s0_kill = 1'b0;
  assign dl_kill = '0;
`endif

  always_comb begin
    dl_vld_d    = '0;
    dl_vld_d[0] = s0_vld_q & ~s0_kill;
    for (int k = 1; k < RD_LAT; k++) begin
      dl_vld_d[k] = dl_vld_q[k-1] & ~dl_kill[k-1];
    end
  end

  assign wr_en_d = dl_vld_q[LAST] & ~dl_kill[LAST];

  // Last delay stage lines up with the bank data returned for the same op.
  for (genvar i = 0; i < NUM_MUL; i++) begin : g_tbl
    logic [DATA_WIDTH-1:0] acc;
    always_comb begin
      acc = dl_ent_q[LAST];
      for (int j = 0; j < OTHERS; j++) begin
        acc = acc ^ bus.rd_other_in[(i*OTHERS + j)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    assign wr_data_d[i*DATA_WIDTH +: DATA_WIDTH] = acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_vld_q  <= 1'b0;
      s0_idx_q  <= '0;
      s0_ent_q  <= '0;
      dl_vld_q  <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        dl_idx_q[k] <= '0;
        dl_ent_q[k] <= '0;
      end
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      s0_vld_q <= accept;
      if (accept) begin
        s0_idx_q <= bus.index_in;
        s0_ent_q <= entry;
      end
      dl_vld_q    <= dl_vld_d;
      dl_idx_q[0] <= s0_idx_q;
      dl_ent_q[0] <= s0_ent_q;
      for (int k = 1; k < RD_LAT; k++) begin
        dl_idx_q[k] <= dl_idx_q[k-1];
        dl_ent_q[k] <= dl_ent_q[k-1];
      end
      wr_en_q <= wr_en_d;
      if (wr_en_d) begin
        wr_idx_q  <= dl_idx_q[LAST];
        wr_data_q <= wr_data_d;
      end
    end
  end

  always_comb begin
    flight = {2'b00, s0_vld_q} + {2'b00, wr_en_q};
    for (int k = 0; k < RD_LAT; k++) begin
      flight = flight + {2'b00, dl_vld_q[k]};
    end
  end

  assign bus.rd_en_out    = s0_vld_q;
  assign bus.rd_index_out = s0_idx_q;
  assign bus.wr_en_out    = wr_en_q;
  assign bus.wr_index_out = wr_idx_q;
  assign bus.wr_data_out  = wr_data_q;
  assign bus.in_flight    = flight;
  assign bus.drain_ack    = bus.drain_req && (flight == 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_xor_write_pipe_uram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_xor_write_pipe_uram : randomized scoreboard bench with a URAM read model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_xor_write_pipe_uram;
  localparam int NUM_MUL     = 4;
  localparam int NUM_WR      = 8;
  localparam int INDEX_WIDTH = 12;
  localparam int VALUE_WIDTH = 31;
  localparam int KEY_WIDTH   = 32;
  localparam int DATA_WIDTH  = 64;
  localparam int RD_LAT      = 2;
  localparam int OW          = NUM_WR - 1;
  localparam int OTH_W       = NUM_MUL*OW*DATA_WIDTH;
  localparam int WR_W        = NUM_MUL*DATA_WIDTH;
  localparam longint LAT     = (RD_LAT + 2)*10;

  typedef logic [OTH_W-1:0] oth_t;
  typedef struct {
    logic [INDEX_WIDTH-1:0] idx;
    logic [WR_W-1:0]        data;
    longint                 atime;
    bit                     killed;
    longint                 ktime;
    bit                     done;
  } op_t;
  typedef struct {
    logic [INDEX_WIDTH-1:0] idx;
    oth_t                   oth;
    longint                 atime;
  } rd_t;

  op_t    ops[$];
  rd_t    rd_q[$];
  oth_t   hist_oth [RD_LAT+1];
  bit     hist_vld [RD_LAT+1];
  int     checks = 0;
  int     errors = 0;
  int     max_if = 0;
  int     wr_seen = 0;
  logic   clk = 1'b0;
  logic   reset = 1'b1;
  bit     drain = 1'b0;

  always #5 clk = ~clk;

  xor_write_pipe_uram_if #(
    .NUM_MUL(NUM_MUL), .NUM_WR(NUM_WR), .INDEX_WIDTH(INDEX_WIDTH),
    .VALUE_WIDTH(VALUE_WIDTH), .KEY_WIDTH(KEY_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) bus ();

  xor_write_pipe_uram #(
    .NUM_MUL(NUM_MUL), .NUM_WR(NUM_WR), .INDEX_WIDTH(INDEX_WIDTH),
    .VALUE_WIDTH(VALUE_WIDTH), .KEY_WIDTH(KEY_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic oth_t rand_oth();
    oth_t r;
    r = '0;
    for (int k = 0; k < (OTH_W + 31)/32; k++) r = (r << 32) | oth_t'($urandom);
    return r;
  endfunction

  // Reference: stored word, then XOR of every other-bank word per table.
  function automatic logic [WR_W-1:0] expect_wr(input logic [1:0] opt,
      input logic [KEY_WIDTH-1:0] key, input logic [VALUE_WIDTH-1:0] val, input oth_t oth);
    logic [DATA_WIDTH-1:0] e;
    logic [DATA_WIDTH-1:0] w;
    logic [WR_W-1:0]       r;
    e = '0;
    e[KEY_WIDTH+VALUE_WIDTH:0] = {~opt[1], val, key};
    r = '0;
    for (int i = 0; i < NUM_MUL; i++) begin
      w = e;
      for (int j = 0; j < OW; j++) w = w ^ oth[(i*OW + j)*DATA_WIDTH +: DATA_WIDTH];
      r[i*DATA_WIDTH +: DATA_WIDTH] = w;
    end
    return r;
  endfunction

  task automatic issue(input bit en, input logic [1:0] opt, input logic [INDEX_WIDTH-1:0] idx,
      input logic [KEY_WIDTH-1:0] key, input logic [VALUE_WIDTH-1:0] val,
      input oth_t oth, input bit drn);
    op_t    o;
    rd_t    r;
    longint t;
    @(negedge clk);
    t = $time;
    #1;
    bus.en_in     = en;
    bus.opt_in    = opt;
    bus.index_in  = idx;
    bus.key_in    = key;
    bus.value_in  = val;
    bus.drain_req = drn;
    drain         = drn;
    if (en && opt != 2'b00 && !drn) begin
`ifdef XORW_COALESCE_EN
      foreach (ops[k]) begin
        if (!ops[k].killed && !ops[k].done && ops[k].idx == idx &&
            t - ops[k].atime <= (RD_LAT + 1)*10) begin
          ops[k].killed = 1'b1;
          ops[k].ktime  = t;
        end
      end
`endif
      o.idx = idx; o.data = expect_wr(opt, key, val, oth); o.atime = t;
      o.killed = 1'b0; o.ktime = 0; o.done = 1'b0;
      ops.push_back(o);
      r.idx = idx; r.oth = oth; r.atime = t;
      rd_q.push_back(r);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) issue(1'b0, 2'b00, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    #1;
    bus.en_in = 1'b0;
    reset     = 1'b1;
    foreach (ops[k]) begin
      if (!ops[k].done && !ops[k].killed) begin
        ops[k].killed = 1'b1;
        ops[k].ktime  = $time - 1;
      end
    end
    rd_q.delete();
    #1;
    chk("rst_wr_en", 64'(bus.wr_en_out), 64'd0);
    chk("rst_in_flight", 64'(bus.in_flight), 64'd0);
    chk("rst_rd_en", 64'(bus.rd_en_out), 64'd0);
    repeat (ncyc) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  // Monitor: in_flight/drain model, URAM read model and write scoreboard.
  always @(negedge clk) begin : mon
    longint t;
    int     cnt;
    int     f;
    rd_t    r;
    t   = $time;
    cnt = 0;
    foreach (ops[k]) begin
      if ((!ops[k].killed || t <= ops[k].ktime) &&
          t - ops[k].atime >= 10 && t - ops[k].atime <= LAT) cnt++;
    end
    chk("in_flight", 64'(bus.in_flight), 64'(cnt));
    chk("drain_ack", 64'(bus.drain_ack), 64'(drain && cnt == 0));
    chk("in_ready", 64'(bus.in_ready), 64'(!drain));
    if (int'(bus.in_flight) > max_if) max_if = int'(bus.in_flight);

    for (int k = RD_LAT; k > 0; k--) begin
      hist_vld[k] = hist_vld[k-1];
      hist_oth[k] = hist_oth[k-1];
    end
    hist_vld[0] = 1'b0;
    if (bus.rd_en_out === 1'b1) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_en: got unexpected read idx %0h expected none at %0t", bus.rd_index_out, t);
      end else begin
        r = rd_q.pop_front();
        chk("rd_index", 64'(bus.rd_index_out), 64'(r.idx));
        hist_vld[0] = 1'b1;
        hist_oth[0] = r.oth;
      end
    end
    if (rd_q.size() != 0 && t - rd_q[0].atime > 10) begin
      checks++; errors++;
      $display("FAIL rd_missing: got no read expected idx %0h at %0t", rd_q[0].idx, t);
      void'(rd_q.pop_front());
    end
    bus.rd_other_in = hist_vld[RD_LAT] ? hist_oth[RD_LAT] : rand_oth();

    if (bus.wr_en_out === 1'b1) begin
      f = -1;
      foreach (ops[k]) if (f < 0 && !ops[k].done && !ops[k].killed) f = k;
      if (f < 0) begin
        checks++; errors++;
        $display("FAIL wr_en: got unexpected write idx %0h expected none at %0t", bus.wr_index_out, t);
      end else begin
        chk("wr_time", 64'(t), 64'(ops[f].atime + LAT));
        chk("wr_index", 64'(bus.wr_index_out), 64'(ops[f].idx));
        for (int i = 0; i < NUM_MUL; i++)
          chk("wr_data", bus.wr_data_out[i*DATA_WIDTH +: DATA_WIDTH],
              ops[f].data[i*DATA_WIDTH +: DATA_WIDTH]);
        ops[f].done = 1'b1;
        wr_seen++;
      end
    end
    foreach (ops[k]) begin
      if (!ops[k].done && !ops[k].killed && t > ops[k].atime + LAT) begin
        checks++; errors++;
        $display("FAIL wr_missing: got no write expected idx %0h at %0t", ops[k].idx, t);
        ops[k].done = 1'b1;
      end
    end
  end

  initial begin : stim
    int w0;
    bus.en_in = 1'b0; bus.opt_in = 2'b00; bus.index_in = '0;
    bus.key_in = '0; bus.value_in = '0; bus.drain_req = 1'b0;
    reset = 1'b1;

    @(negedge clk);
    #1;
    chk("reset_rd_en", 64'(bus.rd_en_out), 64'd0);
    chk("reset_wr_en", 64'(bus.wr_en_out), 64'd0);
    chk("reset_wr_index", 64'(bus.wr_index_out), 64'd0);
    chk("reset_wr_data", bus.wr_data_out[DATA_WIDTH-1:0], 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    #1 reset = 1'b0;

    // Directed insert with zero bank words, then delete with all-ones words.
    issue(1'b1, 2'b01, 12'h005, 32'h12345678, 31'h1, '0, 1'b0);
    idle(6);
    issue(1'b1, 2'b11, 12'h010, $urandom, 31'($urandom), '1, 1'b0);
    idle(6);
    // A read op must not enter the pipeline.
    issue(1'b1, 2'b00, 12'h020, $urandom, 31'($urandom), rand_oth(), 1'b0);
    idle(6);

    for (int i = 1; i <= 5; i++)
      issue(1'b1, 2'b01, 12'(i), $urandom, 31'($urandom), rand_oth(), 1'b0);
    idle(6);
    chk("in_flight_peak", 64'(max_if), 64'(RD_LAT + 2));

    // Drain with en_in held high: only the two earlier ops retire.
    w0 = wr_seen;
    issue(1'b1, 2'b01, 12'h030, $urandom, 31'($urandom), rand_oth(), 1'b0);
    issue(1'b1, 2'b11, 12'h031, $urandom, 31'($urandom), rand_oth(), 1'b0);
    for (int i = 0; i < 8; i++)
      issue(1'b1, 2'b01, 12'($urandom), $urandom, 31'($urandom), rand_oth(), 1'b1);
    idle(4);
    chk("drain_writes", 64'(wr_seen - w0), 64'd2);

    // Reset with three ops in flight: none of them may write.
    w0 = wr_seen;
    for (int i = 0; i < 3; i++)
      issue(1'b1, 2'b01, 12'(8'h40 + i), $urandom, 31'($urandom), rand_oth(), 1'b0);
    do_reset(2);
    idle(8);
    chk("reset_writes", 64'(wr_seen - w0), 64'd0);

    // Two inserts to the same index on consecutive cycles.
    w0 = wr_seen;
    issue(1'b1, 2'b01, 12'h0AA, 32'hAAAA0001, 31'h11, rand_oth(), 1'b0);
    issue(1'b1, 2'b01, 12'h0AA, 32'hAAAA0002, 31'h22, rand_oth(), 1'b0);
    idle(8);
`ifdef XORW_COALESCE_EN
    chk("same_index_writes", 64'(wr_seen - w0), 64'd1);
`else
    chk("same_index_writes", 64'(wr_seen - w0), 64'd2);
`endif

    // Random traffic over a small index range with sporadic drain.
    for (int i = 0; i < 300; i++)
      issue($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 12'($urandom_range(0, 7)),
            $urandom, 31'($urandom), rand_oth(), $urandom_range(0, 9) == 0);
    idle(10);
    chk("reads_outstanding", 64'(rd_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/xor_write_pipe_uram.md
Name: xor_write_pipe_uram

Overview:
- Parametrised write-path pipeline between the hash-function stage and the URAM XOR tables.
- Accepts insert/delete operations and issues a read of the other write-port banks at the target index.
- Waits a configurable URAM read latency, then XORs the new entry with the NUM_WR-1 other-bank words for each of NUM_MUL tables.
- Emits a registered write for every table; adds drain handshake and in-flight tracking.

Parameters:
- NUM_MUL, 4, number of independent hash tables (channels)
- NUM_WR, 8, write ports per table; NUM_WR-1 other-bank words are XORed in
- INDEX_WIDTH, 12, table address width
- VALUE_WIDTH, 31, value field width
- KEY_WIDTH, 32, key field width
- DATA_WIDTH, 64, stored word width; must be >= KEY_WIDTH+VALUE_WIDTH+1
- RD_LAT, 2, cycles from rd_en_out to valid rd_other_in; legal range 1..4

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- en_in  in  1  operation strobe
- opt_in  in  2  00 read (ignored here), 01 insert, 11 delete, 10 treated as delete
- index_in  in  INDEX_WIDTH  target index
- key_in  in  KEY_WIDTH  key
- value_in  in  VALUE_WIDTH  value
- in_ready  out  1  operations accepted when high
- rd_en_out  out  1  read request to other banks
- rd_index_out  out  INDEX_WIDTH  read address
- rd_other_in  in  NUM_MUL*(NUM_WR-1)*DATA_WIDTH  other-bank words; table i at slice i*(NUM_WR-1)*DATA_WIDTH
- wr_en_out  out  1  write strobe
- wr_index_out  out  INDEX_WIDTH  write address
- wr_data_out  out  NUM_MUL*DATA_WIDTH  per-table XORed write word; table i at slice i*DATA_WIDTH
- drain_req  in  1  stop accepting operations and empty the pipeline
- drain_ack  out  1  pipeline empty while drain_req is high
- in_flight  out  3  number of valid stages, 0..RD_LAT+2

Behaviour:
- Reset values:
  - All outputs 0 except in_ready, which is 1 when drain_req=0.
  - All stage valid, index and data registers are cleared.
  - Asserting reset mid-operation discards every in-flight op; no wr_en_out pulse follows reset release.
- Accept condition: en_in && (opt_in != 00) && in_ready, sampled at edge T.
- in_ready = ~drain_req (combinational). Operations presented while in_ready=0 are dropped.
- Entry word:
  - bit KEY+VALUE = ~opt_in[1]
  - [KEY+VALUE-1:KEY] = value_in
  - [KEY-1:0] = key_in
  - All higher bits 0.
- Stage 0 (edge T+1): rd_en_out=1 and rd_index_out=index_in for exactly one cycle; entry and index are captured.
- Delay line: entry, index and valid shift through RD_LAT further registers, aligned so the op is in the final stage when rd_other_in is valid (cycle T+1+RD_LAT).
- Output (edge T+2+RD_LAT):
  - wr_en_out=1; wr_index_out is the op's index.
  - For each table i: wr_data_out[i] = entry XOR all NUM_WR-1 words of rd_other_in slice i.
  - Registered; exactly one cycle per op.
- Latency: fixed at RD_LAT+2 cycles. Throughput is one op per cycle; back-to-back ops produce back-to-back writes in order.
- in_flight:
  - Count of valid bits across stage 0, the delay stages and the output stage.
  - Updated every cycle; an accept and a retire in the same cycle leave it unchanged.
- drain_ack = drain_req && (in_flight == 0), combinational.
- drain_req asserted mid-stream: ops already accepted complete normally; drain_ack rises in the cycle after the last wr_en_out.
- Read ops (opt 00) never enter the pipeline and produce no rd_en_out.

Optional Feature:
- Macro: XORW_COALESCE_EN.
- Defined:
  - When an op is accepted whose index equals that of any older valid op still before the output stage, the older op's valid bit is cleared.
  - The squashed op produces no wr_en_out (it would be overwritten).
  - in_flight decrements accordingly.
  - rd_en_out for the squashed op has already been issued and is not recalled.
- Undefined: every accepted op produces its own write, in order.

Test Plan:
- Reset, then insert idx=0x005 key=0x12345678 val=0x1 with all rd_other_in=0, RD_LAT=2 -> wr_en_out at T+4, wr_index_out=0x005, each table word = {bit63=1, value=0x1, key=0x12345678}.
- Delete idx=0x010 with all other-bank words=0xFFFF_FFFF_FFFF_FFFF, NUM_WR=8 (7 words, odd count) -> each table word = ~{bit63=0, value, key}; rd_en_out pulses at T+1 with rd_index_out=0x010.
- 5 back-to-back inserts to idx 1..5 -> 5 consecutive wr_en_out cycles in order; in_flight peaks at 4.
- Assert drain_req while 2 ops are in flight, with en_in held high -> new ops dropped, 2 writes emitted, drain_ack=1 one cycle after the last write.
- Assert reset while 3 ops are in flight -> wr_en_out=0, in_flight=0 immediately; no writes after release.
- With XORW_COALESCE_EN, two inserts to idx 0x0AA on consecutive cycles -> one wr_en_out carrying the second key; without the macro -> two writes.
